uart_tx_io: RTL and testbench

- Memory-mapped UART transmitter: the send direction to complement the UART programmer's receive path, so programs can print bytes to the host over `tx`.
- Sits on the IO bus beside `led`/`switch`, selected by a chip-select from `MemOrIO`, driven by `IOWrite`/`IORead` and `alu_result[1:0]`.
- CPU pushes bytes into a TX FIFO; an 8N1 serializer drains it at a fixed baud.

---
 rtl/uart_tx_io.sv | 108 ++++++++++
 tb/tb_uart_tx_io.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with a TX FIFO and STATUS/CTRL registers
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        uartcs,
  input  logic        uartwrite,
  input  logic        uartread,
  input  logic [1:0]  uartaddr,
  input  logic [15:0] uartwdata,
  output logic [15:0] uartrdata_out,
  output logic        tx,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic ovf, ovf_n, tx_n, full, empty, push_req, push, pop, ctrl_wr, baud_end;
  logic unused_wdata;
  assign unused_wdata = ^uartwdata[15:8];
  assign full = count == (PTR_W+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign push_req = uartcs & uartwrite & (uartaddr == 2'b00);
  assign push = push_req & ~full;
  assign ctrl_wr = uartcs & uartwrite & (uartaddr == 2'b10) & uartwdata[3];
  assign baud_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign busy = (state != IDLE) | ~empty;
  assign uartrdata_out = (uartcs & uartread & (uartaddr == 2'b10)) ? {12'b0, ovf, busy, full, empty} : 16'h0;
  // a push into a full FIFO is dropped even if the serializer pops in the same cycle
  assign ovf_n = (ovf & ~ctrl_wr) | (push_req & full);
  assign tx_n = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        state_n = START;
        shift_n = mem[rd_ptr];
        cnt_n = '0;
        idx_n = '0;
      end
      START: begin
        cnt_n = baud_end ? '0 : cnt + 1'b1;
        if (baud_end) state_n = DATA;
      end
      DATA: begin
        cnt_n = baud_end ? '0 : cnt + 1'b1;
        if (baud_end) begin
          shift_n = shift >> 1;
          idx_n = idx + 1'b1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        cnt_n = baud_end ? '0 : cnt + 1'b1;
        if (baud_end) begin
          state_n = IDLE;
          // chain straight into the next frame so queued bytes leave with no idle gap
          if (!empty) begin
            pop = 1'b1;
            state_n = START;
            shift_n = mem[rd_ptr];
            idx_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(push);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      ovf <= ovf_n;
    end
  end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= uartwdata[7:0];
endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: directed bench for uart_tx_io with CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_uart_tx_io;
  logic clock = 0, rst = 1, uartcs = 0, uartwrite = 0, uartread = 0;
  logic [1:0] uartaddr = 0;
  logic [15:0] uartwdata = 0;
  logic [15:0] uartrdata_out;
  logic tx, busy;
  int checks = 0, errors = 0, rst_falls = 0;
  logic [7:0] rxq [$];

  always #5 clock = ~clock;
  always @(negedge rst) rst_falls++;

  uart_tx_io #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .rst(rst), .uartcs(uartcs), .uartwrite(uartwrite), .uartread(uartread),
    .uartaddr(uartaddr), .uartwdata(uartwdata), .uartrdata_out(uartrdata_out), .tx(tx), .busy(busy)
  );

  // serial receiver model: samples mid-bit on falling clock edges, drops frames hit by reset
  initial begin : rx
    logic [7:0] b;
    logic ok;
    int f0;
    forever begin
      @(negedge clock);
      if (rst === 1'b1 && tx === 1'b0) begin
        f0 = rst_falls;
        ok = 1;
        repeat (2) @(negedge clock);
        if (tx !== 1'b0) ok = 0;
        for (int d = 0; d < 8; d++) begin
          repeat (4) @(negedge clock);
          b[d] = tx;
        end
        repeat (4) @(negedge clock);
        if (tx !== 1'b1) ok = 0;
        if (ok && rst_falls == f0) rxq.push_back(b);
      end
    end
  end

  function automatic logic fbit(input logic [7:0] d, input int k);
    if (k < 4) return 1'b0;
    if (k < 36) return d[(k-4)/4];
    return 1'b1;
  endfunction

  task automatic bus_wr(input logic cs, input logic [1:0] a, input logic [15:0] d);
    uartcs = cs; uartwrite = 1; uartaddr = a; uartwdata = d;
    @(negedge clock);
    uartcs = 0; uartwrite = 0; uartaddr = 0; uartwdata = 0;
  endtask

  task automatic bus_rd(input logic cs, input logic [1:0] a, output logic [15:0] v);
    uartcs = cs; uartread = 1; uartaddr = a;
    #1 v = uartrdata_out;
    uartcs = 0; uartread = 0; uartaddr = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy); end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset;
    logic [15:0] v;
    #2 rst = 0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (uartrdata_out !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", uartrdata_out); end
    repeat (2) @(negedge clock);
    rst = 1;
    @(negedge clock);
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL reset_status: got %h expected 0001", v); end
  endtask

  task automatic test_frame;
    logic [15:0] v;
    rxq.delete();
    @(negedge clock);
    bus_wr(1, 2'b00, 16'hAB55);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_rise: got %b expected 1", busy); end
    @(negedge clock);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_pop_cycle_tx: got %b expected 1", tx); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      checks++;
      if (tx !== fbit(8'h55, k)) begin errors++; $display("FAIL frame_tx[%0d]: got %b expected %b", k, tx, fbit(8'h55, k)); end
      checks++;
      if (busy !== (k < 39)) begin errors++; $display("FAIL frame_busy[%0d]: got %b expected %b", k, busy, k < 39); end
    end
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL frame_status: got %h expected 0001", v); end
    checks++; if (rxq.size() != 1 || rxq[0] !== 8'h55) begin errors++; $display("FAIL frame_rx: got %0d bytes expected one 55", rxq.size()); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
    rxq.delete();
    @(negedge clock);
    bus_wr(1, 2'b00, 16'h0041);
    bus_wr(1, 2'b00, 16'h0042);
    bus_wr(1, 2'b00, 16'h0043);
    for (int k = 0; k < 120; k++) begin
      if (k > 0) @(negedge clock);
      checks++;
      if (tx !== fbit(exp_b[k/40], k%40)) begin errors++; $display("FAIL b2b_tx[%0d]: got %b expected %b", k, tx, fbit(exp_b[k/40], k%40)); end
      if (k < 119) begin
        bus_rd(1, 2'b10, v);
        checks++;
        if (v[2] !== 1'b1) begin errors++; $display("FAIL b2b_status_busy[%0d]: got %h expected bit2 set", k, v); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
    checks++;
    if (rxq.size() != 3 || rxq[0] !== 8'h41 || rxq[1] !== 8'h42 || rxq[2] !== 8'h43) begin
      errors++; $display("FAIL b2b_rx: got %0d bytes expected 41 42 43", rxq.size());
    end
  endtask

  task automatic test_overflow;
    logic [15:0] v;
    rxq.delete();
    @(negedge clock);
    bus_wr(1, 2'b00, 16'h00A1);
    for (int i = 1; i <= 5; i++) bus_wr(1, 2'b00, 16'h00B0 + 16'(i));
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h000E) begin errors++; $display("FAIL ovf_status: got %h expected 000e", v); end
    bus_wr(1, 2'b10, 16'h0008);
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h0006) begin errors++; $display("FAIL ovf_clear_status: got %h expected 0006", v); end
    wait_idle("ovf");
    checks++;
    if (rxq.size() != 5 || rxq[0] !== 8'hA1 || rxq[1] !== 8'hB1 || rxq[2] !== 8'hB2 || rxq[3] !== 8'hB3 || rxq[4] !== 8'hB4) begin
      errors++; $display("FAIL ovf_rx: got %0d bytes expected a1 b1 b2 b3 b4", rxq.size());
    end
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL ovf_end_status: got %h expected 0001", v); end
  endtask

  task automatic test_full_pop;
    logic [15:0] v;
    rxq.delete();
    @(negedge clock);
    for (int i = 0; i <= 4; i++) bus_wr(1, 2'b00, 16'h00C0 + 16'(i));
    repeat (36) @(negedge clock);
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h0006) begin errors++; $display("FAIL fullpop_before: got %h expected 0006", v); end
    bus_wr(1, 2'b00, 16'h00C5);
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h000C) begin errors++; $display("FAIL fullpop_after: got %h expected 000c", v); end
    wait_idle("fullpop");
    checks++;
    if (rxq.size() != 5 || rxq[0] !== 8'hC0 || rxq[1] !== 8'hC1 || rxq[2] !== 8'hC2 || rxq[3] !== 8'hC3 || rxq[4] !== 8'hC4) begin
      errors++; $display("FAIL fullpop_rx: got %0d bytes expected c0 c1 c2 c3 c4", rxq.size());
    end
    bus_wr(1, 2'b10, 16'h0008);
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL fullpop_clear: got %h expected 0001", v); end
  endtask

  task automatic test_no_select;
    logic [15:0] v;
    logic stayed_high = 1;
    rxq.delete();
    @(negedge clock);
    bus_wr(0, 2'b00, 16'h0077);
    bus_wr(1, 2'b01, 16'h0066);
    bus_wr(1, 2'b11, 16'h0055);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nosel_busy: got %b expected 0", busy); end
    bus_rd(0, 2'b10, v);
    checks++; if (v !== 16'h0) begin errors++; $display("FAIL nosel_rd_nocs: got %h expected 0000", v); end
    bus_rd(1, 2'b00, v);
    checks++; if (v !== 16'h0) begin errors++; $display("FAIL nosel_rd_a0: got %h expected 0000", v); end
    bus_rd(1, 2'b01, v);
    checks++; if (v !== 16'h0) begin errors++; $display("FAIL nosel_rd_a1: got %h expected 0000", v); end
    bus_rd(1, 2'b11, v);
    checks++; if (v !== 16'h0) begin errors++; $display("FAIL nosel_rd_a3: got %h expected 0000", v); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) stayed_high = 0;
    end
    checks++; if (!stayed_high) begin errors++; $display("FAIL nosel_tx_idle: got activity expected constant 1"); end
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL nosel_status: got %h expected 0001", v); end
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL nosel_rx: got %0d bytes expected 0", rxq.size()); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    logic stayed_high = 1;
    rxq.delete();
    @(negedge clock);
    bus_wr(1, 2'b00, 16'h0000);
    repeat (15) @(negedge clock);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx: got %b expected 0", tx); end
    rst = 0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    repeat (2) @(negedge clock);
    rst = 1;
    @(negedge clock);
    bus_rd(1, 2'b10, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL rstmid_status: got %h expected 0001", v); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) stayed_high = 0;
    end
    checks++; if (!stayed_high) begin errors++; $display("FAIL rstmid_residual: got activity expected constant 1"); end
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL rstmid_rx: got %0d bytes expected 0", rxq.size()); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_no_select();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
